// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter between the I-cache and D-cache.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEFAULT_ADDR_WIDTH = 28;
  localparam int DEFAULT_DATA_WIDTH = 128;

  function automatic logic other_owner(input logic owner);
    return (owner == OWNER_I) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not own memory last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_owner = OWNER_I;
    if (req_i && req_d) begin
      grant_owner = other_owner(last_owner);
    end else if (req_d) begin
      grant_owner = OWNER_D;
    end
  end

endmodule

// File: rtl/main_memory_arbiter.sv
// Shares one block-granular main-memory port between the I-cache and D-cache;
// the loser's busywait stays high until its own transaction is released.
module main_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_readdata,
  output logic                  i_busywait,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_writedata,
  output logic [DATA_WIDTH-1:0] d_readdata,
  output logic                  d_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  arb_state_t state;
  logic       owner;
  logic       op;
  logic       last_owner;
  logic       i_pending;
  logic       d_pending;
  logic       grant_valid;
  logic       grant_owner;

  assign i_pending = i_read;
  assign d_pending = d_read | d_write;

  rr_pick2 u_pick (
    .req_i       (i_pending),
    .req_d       (d_pending),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // The owner is released only in RELEASE, so its stall drops exactly one cycle.
  assign i_busywait = i_pending && !(state == RELEASE && owner == OWNER_I);
  assign d_busywait = d_pending && !(state == RELEASE && owner == OWNER_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWNER_I;
      last_owner    <= OWNER_I;
      op            <= OP_READ;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner <= grant_owner;
            state <= GRANT;
            if (grant_owner == OWNER_D) begin
              // A simultaneous read and write from the D-cache is a write-back.
              op          <= d_write ? OP_WRITE : OP_READ;
              mem_read    <= !d_write;
              mem_write   <= d_write;
              mem_address <= d_address;
              if (d_write) begin
                mem_writedata <= d_writedata;
              end
            end else begin
              op          <= OP_READ;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
              mem_address <= i_address;
            end
          end
        end
        GRANT: begin
          if (!mem_busywait) begin
            if (op == OP_READ) begin
              if (owner == OWNER_I) begin
                i_readdata <= mem_readdata;
              end else begin
                d_readdata <= mem_readdata;
              end
            end
            last_owner <= owner;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Shares one main-memory port between the instruction cache (behind the fetch unit) and the data cache (behind the memory-access unit). Requests are block-granular. The arbiter:
- picks a winner with two-way round-robin;
- latches the winner's address and data and drives a single transaction;
- returns read data to the winner;
- holds the loser's busywait high until its turn comes.

The requester-side busywait signals feed the existing pipeline stall path unchanged.

## Interface
Parameters:
- ADDR_WIDTH, 28, block address width (byte address >> 4)
- DATA_WIDTH, 128, block width in bits

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- i_read  in  1  I-cache block read request
- i_address  in  ADDR_WIDTH  I-cache block address
- i_readdata  out  DATA_WIDTH  block returned to I-cache
- i_busywait  out  1  I-cache stall
- d_read  in  1  D-cache block read request
- d_write  in  1  D-cache block write-back request
- d_address  in  ADDR_WIDTH  D-cache block address
- d_writedata  in  DATA_WIDTH  D-cache write-back block
- d_readdata  out  DATA_WIDTH  block returned to D-cache
- d_busywait  out  1  D-cache stall
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  memory block address
- mem_writedata  out  DATA_WIDTH  memory write block
- mem_readdata  in  DATA_WIDTH  memory read block, valid in completion cycle
- mem_busywait  in  1  memory busy; rises combinationally with a strobe, low in the completion cycle

## Operation
- States:
  - IDLE: memory strobes low; sample requests.
  - GRANT: strobe driven for the owner.
  - RELEASE: strobes low for one cycle; owner released.
- A requester is pending when:
  - I: i_read is high.
  - D: d_read or d_write is high.
  - If d_read and d_write are both high, the transaction is a write.
- IDLE, one requester pending: that requester wins; go to GRANT.
- IDLE, both pending: the requester other than last_owner wins.
  - last_owner resets to I, so D wins the first tie.
- On the IDLE→GRANT edge, latch into registers:
  - owner;
  - op (read/write);
  - mem_address;
  - mem_writedata (D write only).
- GRANT:
  - mem_read = (op==read); mem_write = (op==write).
  - Stay in GRANT while mem_busywait is 1.
  - A GRANT cycle with mem_busywait==0 is completion. At that edge:
    - on a read, capture mem_readdata into the owner's readdata register;
    - update last_owner to owner;
    - go to RELEASE.
- RELEASE:
  - Strobes are low, so memory sees the request fall.
  - Requests are ignored.
  - Go to IDLE next.
- Busywait is combinational:
  - x_busywait = x_pending && !(state==RELEASE && owner==x).
  - The requester must drop its request in the RELEASE cycle.
- i_readdata and d_readdata hold their value until the next read completion for that requester. A write does not change d_readdata.
- A request that drops while pending in IDLE is withdrawn. A request that drops during GRANT does not abort: the transaction completes and its data is discarded by the requester.
- Reset (any state, including mid-GRANT):
  - state IDLE, owner I, last_owner I;
  - mem_read, mem_write, mem_address, mem_writedata all 0;
  - i_readdata and d_readdata both 0.
  - Busywaits follow their formula, so they equal the pending flags.
  - An in-flight memory transaction is abandoned. Memory must tolerate the strobe falling.

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: mem strobe high.
- Memory busy L cycles, then a completion cycle C.
- Cycle C+1: RELEASE, owner busywait low, readdata valid.
- Cycle C+2: IDLE.
- Uncontended occupancy is L+3 cycles. A losing requester waits at most one full transaction plus its own.
- Back-to-back: the next IDLE cycle can grant immediately. There is no idle bubble beyond RELEASE.
- All state and output registers update on posedge clk only.

## Structure
- Shared package mem_arb_pkg:
  - arb_state_t enum {IDLE, GRANT, RELEASE};
  - owner encoding OWNER_I=0, OWNER_D=1;
  - OP_READ/OP_WRITE constants;
  - default widths 28/128.
- One sub-module, rr_pick2: combinational two-way round-robin picker.
  - Inputs: req_i, req_d, last_owner.
  - Outputs: grant_valid, grant_owner.
- Everything else (FSM, latches, readdata registers) lives in the top block.

## Test plan
- Reset, then I read at 0x0000010, memory L=4 returning 0xA5…A5:
  - mem_read high cycles 1–5;
  - i_busywait low and i_readdata=0xA5…A5 at cycle 6 (RELEASE);
  - IDLE at cycle 7.
- I read 0x10 and D read 0x20 in the same cycle after reset:
  - D granted first (mem_address=0x20);
  - i_busywait stays high;
  - I granted on the IDLE cycle right after D's RELEASE;
  - i_readdata differs from d_readdata.
- Both requesters pending continuously for 4 transactions: grant sequence is D, I, D, I.
- D asserts d_read and d_write together at 0x30 with d_writedata 0x1234:
  - mem_write=1, mem_read=0, mem_writedata=0x1234;
  - d_readdata unchanged after completion.
- Reset asserted during GRANT, after 2 busy cycles of a D read:
  - next cycle: strobes 0, state IDLE, both readdata registers 0;
  - then a tied request grants D.
- Memory L=0 (mem_busywait low in the first GRANT cycle):
  - completion on the first GRANT edge;
  - RELEASE next cycle;
  - total occupancy 3 cycles.
